// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control sequencer for the multi-cycle MIPS datapath.
// Optional feature macro: OVERFLOW_TRAP_EN (trap signed overflow at add/sub/addi write-back).
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       Jal,
  output logic [1:0] DatatoReg,
  output logic       ALUSrc_A,
  output logic [1:0] ALUSrc_B,
  output logic [2:0] ALU_Control,
  output logic [1:0] PCSource,
  output logic [1:0] Branch,
  output logic       RegWrite,
  output logic       trap,
  output logic [3:0] state
);

  localparam logic [3:0] S_IF   = 4'd0,  S_ID   = 4'd1,  S_MADDR = 4'd2,  S_MRD = 4'd3;
  localparam logic [3:0] S_LWB  = 4'd4,  S_MWR  = 4'd5,  S_REX   = 4'd6,  S_RWB = 4'd7;
  localparam logic [3:0] S_BR   = 4'd8,  S_J    = 4'd9,  S_IEX   = 4'd10, S_IWB = 4'd11;
  localparam logic [3:0] S_JAL  = 4'd12, S_JR   = 4'd13, S_TRAP  = 4'd14, S_RST = 4'd15;

  localparam logic [5:0] OP_R   = 6'b000000, OP_LW   = 6'b100011, OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE  = 6'b000101, OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LUI = 6'b001111;

  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101, F_XOR = 6'b100110, F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010, F_SRL = 6'b000010, F_JR  = 6'b001000;

  function automatic logic r_legal(input logic [5:0] f);
    case (f)
      F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SRL: r_legal = 1'b1;
      default: r_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] f);
    case (f)
      F_ADD:   r_alu = 3'b010;
      F_SUB:   r_alu = 3'b110;
      F_AND:   r_alu = 3'b000;
      F_OR:    r_alu = 3'b001;
      F_XOR:   r_alu = 3'b011;
      F_NOR:   r_alu = 3'b100;
      F_SLT:   r_alu = 3'b111;
      F_SRL:   r_alu = 3'b101;
      default: r_alu = 3'b000;
    endcase
  endfunction

  logic [3:0] nxt;
  logic       ovf_trap;

`ifdef OVERFLOW_TRAP_EN
  assign ovf_trap = overflow &
                    (((state == S_RWB) && ((funct == F_ADD) || (funct == F_SUB))) ||
                     ((state == S_IWB) && (opcode == OP_ADDI)));
`else
  assign ovf_trap = overflow & 1'b0;
`endif

  always_comb begin
    nxt = S_IF;
    case (state)
      S_IF:    nxt = mem_ready ? S_ID : S_IF;
      S_ID: begin
        case (opcode)
          OP_R:                   nxt = (funct == F_JR) ? S_JR : S_REX;
          OP_LW, OP_SW:           nxt = S_MADDR;
          OP_BEQ, OP_BNE:         nxt = S_BR;
          OP_J:                   nxt = S_J;
          OP_JAL:                 nxt = S_JAL;
          OP_ADDI, OP_SLTI, OP_LUI: nxt = S_IEX;
          default:                nxt = S_TRAP;
        endcase
      end
      S_MADDR: nxt = (opcode == OP_LW) ? S_MRD : S_MWR;
      S_MRD:   nxt = mem_ready ? S_LWB : S_MRD;
      S_MWR:   nxt = mem_ready ? S_IF : S_MWR;
      S_REX:   nxt = r_legal(funct) ? S_RWB : S_TRAP;
      S_RWB:   nxt = ovf_trap ? S_TRAP : S_IF;
      S_IEX:   nxt = S_IWB;
      S_IWB:   nxt = ovf_trap ? S_TRAP : S_IF;
      default: nxt = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_RST;
    else     state <= nxt;
  end

  // Control decode; everything is forced low while rst is asserted.
  always_comb begin
    PCWrite = 1'b0; IorD = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0;
    RegDst = 1'b0; Jal = 1'b0; DatatoReg = 2'b00; ALUSrc_A = 1'b0; ALUSrc_B = 2'b00;
    ALU_Control = 3'b000; PCSource = 2'b00; Branch = 2'b00; RegWrite = 1'b0; trap = 1'b0;
    if (!rst) begin
      case (state)
        S_IF: begin
          MemRead = 1'b1; ALUSrc_B = 2'b01; ALU_Control = 3'b010;
          PCWrite = mem_ready; IRWrite = mem_ready;
        end
        S_ID:    begin ALUSrc_B = 2'b11; ALU_Control = 3'b010; end
        S_MADDR: begin ALUSrc_A = 1'b1; ALUSrc_B = 2'b10; ALU_Control = 3'b010; end
        S_MRD:   begin MemRead = 1'b1; IorD = 1'b1; end
        S_MWR:   begin MemWrite = 1'b1; IorD = 1'b1; end
        S_LWB:   begin RegWrite = 1'b1; DatatoReg = 2'b01; end
        S_REX:   begin ALUSrc_A = 1'b1; ALU_Control = r_alu(funct); end
        S_RWB:   begin RegWrite = ~ovf_trap; RegDst = 1'b1; ALU_Control = r_alu(funct); end
        S_BR: begin
          ALUSrc_A = 1'b1; ALU_Control = 3'b110; PCSource = 2'b01;
          Branch  = (opcode == OP_BEQ) ? 2'b01 : 2'b10;
          PCWrite = (opcode == OP_BEQ) ? zero : ~zero;
        end
        S_J:     begin PCWrite = 1'b1; PCSource = 2'b10; end
        S_JAL: begin
          PCWrite = 1'b1; PCSource = 2'b10; RegWrite = 1'b1; Jal = 1'b1; DatatoReg = 2'b10;
        end
        S_JR:    begin ALUSrc_A = 1'b1; ALU_Control = 3'b001; PCWrite = 1'b1; end
        S_IEX: begin
          ALUSrc_A = 1'b1; ALUSrc_B = 2'b10;
          ALU_Control = (opcode == OP_SLTI) ? 3'b111 : 3'b010;
        end
        S_IWB: begin
          RegWrite  = ~ovf_trap;
          DatatoReg = (opcode == OP_LUI) ? 2'b11 : 2'b00;
        end
        S_TRAP:  begin trap = 1'b1; PCWrite = 1'b1; PCSource = 2'b11; end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: instruction-level model pushes per-cycle expectations.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       PCWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       Jal;
    logic [1:0] DatatoReg;
    logic       ALUSrc_A;
    logic [1:0] ALUSrc_B;
    logic [2:0] ALU_Control;
    logic [1:0] PCSource;
    logic [1:0] Branch;
    logic       RegWrite;
    logic       trap;
  } ctrl_t;

  typedef struct packed {
    int         kind;
    logic [3:0] st;
    ctrl_t      c;
  } exp_t;

`ifdef OVERFLOW_TRAP_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  // instruction kinds
  localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_OR = 3, K_XOR = 4, K_NOR = 5, K_SLT = 6;
  localparam int K_SRL = 7, K_LW = 8, K_SW = 9, K_BEQ = 10, K_BNE = 11, K_J = 12, K_JAL = 13;
  localparam int K_JR = 14, K_ADDI = 15, K_SLTI = 16, K_LUI = 17, K_BADOP = 18, K_BADFN = 19;

  logic clk = 1'b0, rst = 1'b1;
  logic [5:0] opcode = 6'd0, funct = 6'd0;
  logic zero = 1'b0, overflow = 1'b0, mem_ready = 1'b0;
  logic PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, Jal, ALUSrc_A, RegWrite, trap;
  logic [1:0] DatatoReg, ALUSrc_B, PCSource, Branch;
  logic [2:0] ALU_Control;
  logic [3:0] state;
  ctrl_t act;

  exp_t exp_q[$];
  int errors = 0, checks = 0, cur_kind = -1;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .overflow(overflow),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .Jal(Jal),
    .DatatoReg(DatatoReg), .ALUSrc_A(ALUSrc_A), .ALUSrc_B(ALUSrc_B),
    .ALU_Control(ALU_Control), .PCSource(PCSource), .Branch(Branch),
    .RegWrite(RegWrite), .trap(trap), .state(state)
  );

  always #5 clk = ~clk;

  assign act = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, Jal, DatatoReg, ALUSrc_A,
                ALUSrc_B, ALU_Control, PCSource, Branch, RegWrite, trap};

  // monitor: one expectation per cycle, checked mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (state !== e.st || act !== e.c) begin
          errors++;
          $display("FAIL kind=%0d t=%0t: state got %0d want %0d, ctrl got %h want %h",
                   e.kind, $time, state, e.st, act, e.c);
        end
      end
    end
  end

  function automatic ctrl_t z();
    ctrl_t c;
    c = '0;
    return c;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit legal_op(input logic [5:0] op);
    case (op)
      6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
      6'b000011, 6'b001000, 6'b001010, 6'b001111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] r_op(input int k);
    case (k)
      K_ADD: return 3'b010;
      K_SUB: return 3'b110;
      K_AND: return 3'b000;
      K_OR:  return 3'b001;
      K_XOR: return 3'b011;
      K_NOR: return 3'b100;
      K_SLT: return 3'b111;
      K_SRL: return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  task automatic step(input logic [3:0] st, input ctrl_t c, input logic mr);
    exp_t e;
    mem_ready = mr;
    e.kind = cur_kind;
    e.st = st;
    e.c = c;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic trap_step();
    ctrl_t c;
    c = z(); c.trap = 1'b1; c.PCWrite = 1'b1; c.PCSource = 2'b11;
    step(4'd14, c, rb());
  endtask

  task automatic set_instr(input int k);
    logic [5:0] bad;
    case (k)
      K_ADD: begin opcode = 6'b000000; funct = 6'b100000; end
      K_SUB: begin opcode = 6'b000000; funct = 6'b100010; end
      K_AND: begin opcode = 6'b000000; funct = 6'b100100; end
      K_OR:  begin opcode = 6'b000000; funct = 6'b100101; end
      K_XOR: begin opcode = 6'b000000; funct = 6'b100110; end
      K_NOR: begin opcode = 6'b000000; funct = 6'b100111; end
      K_SLT: begin opcode = 6'b000000; funct = 6'b101010; end
      K_SRL: begin opcode = 6'b000000; funct = 6'b000010; end
      K_JR:  begin opcode = 6'b000000; funct = 6'b001000; end
      K_LW:  opcode = 6'b100011;
      K_SW:  opcode = 6'b101011;
      K_BEQ: opcode = 6'b000100;
      K_BNE: opcode = 6'b000101;
      K_J:   opcode = 6'b000010;
      K_JAL: opcode = 6'b000011;
      K_ADDI: opcode = 6'b001000;
      K_SLTI: opcode = 6'b001010;
      K_LUI: opcode = 6'b001111;
      K_BADFN: begin
        opcode = 6'b000000;
        case ($urandom_range(0, 3))
          0: funct = 6'b000000;
          1: funct = 6'b100001;
          2: funct = 6'b000011;
          default: funct = 6'b111111;
        endcase
      end
      default: begin
        bad = 6'b111111;
        if ($urandom_range(0, 1) == 1) begin
          do bad = 6'($urandom_range(0, 63)); while (legal_op(bad));
        end
        opcode = bad;
      end
    endcase
    if (k >= K_LW && k != K_JR && k != K_BADFN) funct = 6'($urandom_range(0, 63));
  endtask

  // One instruction from fetch to return to IF, at the level of architectural phases.
  task automatic run_instr(input int k, input int if_w, input int mem_w,
                           input logic zf, input logic ov, input bit rst_mid);
    ctrl_t c;
    bit tr;
    cur_kind = k;
    set_instr(k);
    zero = zf;
    overflow = ov;
    c = z(); c.MemRead = 1'b1; c.ALUSrc_B = 2'b01; c.ALU_Control = 3'b010;
    for (int i = 0; i < if_w; i++) step(4'd0, c, 1'b0);
    c.PCWrite = 1'b1; c.IRWrite = 1'b1;
    step(4'd0, c, 1'b1);
    c = z(); c.ALUSrc_B = 2'b11; c.ALU_Control = 3'b010;
    step(4'd1, c, rb());
    if (k <= K_SRL || k == K_BADFN) begin
      c = z(); c.ALUSrc_A = 1'b1; c.ALU_Control = r_op(k);
      step(4'd6, c, rb());
      if (k == K_BADFN) trap_step();
      else begin
        tr = OVF_EN && ov && (k == K_ADD || k == K_SUB);
        c = z(); c.RegWrite = !tr; c.RegDst = 1'b1; c.ALU_Control = r_op(k);
        step(4'd7, c, rb());
        if (tr) trap_step();
      end
    end else begin
      case (k)
        K_LW, K_SW: begin
          c = z(); c.ALUSrc_A = 1'b1; c.ALUSrc_B = 2'b10; c.ALU_Control = 3'b010;
          step(4'd2, c, rb());
          c = z(); c.IorD = 1'b1;
          if (k == K_LW) c.MemRead = 1'b1; else c.MemWrite = 1'b1;
          for (int i = 0; i < mem_w; i++) step((k == K_LW) ? 4'd3 : 4'd5, c, 1'b0);
          if (rst_mid) begin
            rst = 1'b1;
            step((k == K_LW) ? 4'd3 : 4'd5, z(), rb());
            rst = 1'b0;
            step(4'd15, z(), rb());
            return;
          end
          step((k == K_LW) ? 4'd3 : 4'd5, c, 1'b1);
          if (k == K_LW) begin
            c = z(); c.RegWrite = 1'b1; c.DatatoReg = 2'b01;
            step(4'd4, c, rb());
          end
        end
        K_BEQ, K_BNE: begin
          c = z(); c.ALUSrc_A = 1'b1; c.ALU_Control = 3'b110; c.PCSource = 2'b01;
          c.Branch = (k == K_BEQ) ? 2'b01 : 2'b10;
          c.PCWrite = (k == K_BEQ) ? zf : !zf;
          step(4'd8, c, rb());
        end
        K_J: begin
          c = z(); c.PCWrite = 1'b1; c.PCSource = 2'b10;
          step(4'd9, c, rb());
        end
        K_JAL: begin
          c = z(); c.PCWrite = 1'b1; c.PCSource = 2'b10; c.RegWrite = 1'b1;
          c.Jal = 1'b1; c.DatatoReg = 2'b10;
          step(4'd12, c, rb());
        end
        K_JR: begin
          c = z(); c.ALUSrc_A = 1'b1; c.ALU_Control = 3'b001; c.PCWrite = 1'b1;
          step(4'd13, c, rb());
        end
        K_ADDI, K_SLTI, K_LUI: begin
          c = z(); c.ALUSrc_A = 1'b1; c.ALUSrc_B = 2'b10;
          c.ALU_Control = (k == K_SLTI) ? 3'b111 : 3'b010;
          step(4'd10, c, rb());
          tr = OVF_EN && ov && (k == K_ADDI);
          c = z(); c.RegWrite = !tr; c.DatatoReg = (k == K_LUI) ? 2'b11 : 2'b00;
          step(4'd11, c, rb());
          if (tr) trap_step();
        end
        default: trap_step();
      endcase
    end
  endtask

  initial begin
    int k;
    rst = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    step(4'd15, z(), 1'b1);
    step(4'd15, z(), 1'b1);
    rst = 1'b0;
    step(4'd15, z(), 1'b1);

    run_instr(K_NOR, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(K_LW, 0, 2, 1'b0, 1'b0, 1'b0);
    run_instr(K_BNE, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(K_BNE, 1, 0, 1'b1, 1'b0, 1'b0);
    run_instr(K_BEQ, 0, 0, 1'b1, 1'b0, 1'b0);
    run_instr(K_BADOP, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(K_ADD, 0, 0, 1'b0, 1'b1, 1'b0);
    run_instr(K_ADDI, 0, 0, 1'b0, 1'b1, 1'b0);
    run_instr(K_SW, 2, 1, 1'b0, 1'b0, 1'b0);
    run_instr(K_LW, 0, 1, 1'b0, 1'b0, 1'b1);

    for (int n = 0; n < 250; n++) begin
      k = $urandom_range(0, 19);
      run_instr(k, $urandom_range(0, 2), $urandom_range(0, 2), rb(), rb(),
                ($urandom_range(0, 7) == 0));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the MIPS datapath (`Data_path_more` family). Decodes the latched instruction's opcode/funct and steps a Moore FSM through fetch, decode, execute, memory and write-back, driving every datapath control line each cycle. It stalls on a memory ready handshake and traps illegal opcodes. It replaces hand-driven control vectors in datapath benches and is the control half of the multi-cycle CPU.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- opcode  in  6  instr[31:26] from the datapath IR; stable from ID onward.
- funct  in  6  instr[5:0] from the datapath IR.
- zero  in  1  ALU zero flag.
- overflow  in  1  ALU signed-overflow flag.
- mem_ready  in  1  memory completes the current read or write this cycle.
- PCWrite  out  1  load PC.
- IorD  out  1  memory address source: 0 = PC, 1 = ALU_out.
- MemRead / MemWrite  out  1 each  memory strobes, held until mem_ready.
- IRWrite  out  1  latch IR.
- RegDst  out  1  destination: 1 = rd, 0 = rt.
- Jal  out  1  force destination to r31.
- DatatoReg  out  2  write-back source: 00 ALU_out, 01 Data_in, 10 pc_4, 11 {imm,16'h0}.
- ALUSrc_A  out  1  ALU A input: 0 = PC, 1 = reg A.
- ALUSrc_B  out  2  ALU B input: 00 reg B, 01 constant 4, 10 sext(imm), 11 sext(imm)<<2.
- ALU_Control  out  3  ALU operation: 000 and, 001 or, 010 add, 011 xor, 100 nor, 101 srl, 110 sub, 111 slt.
- PCSource  out  2  PC source: 00 ALU result, 01 ALU_out, 10 jump target, 11 trap vector 32'h0000_0004.
- Branch  out  2  branch type: 01 beq, 10 bne, 00 none. Informational only.
- RegWrite  out  1  register file write enable.
- trap  out  1  one-cycle pulse when entering the trap vector.
- state  out  4  current FSM state, for debug.

## Operation
- Outputs are a pure decode of the state register, plus opcode/funct where noted. Every output not listed for a state is 0.
- State encoding:
  - 0 IF, 1 ID, 2 MADDR, 3 MRD, 4 LWB, 5 MWR, 6 REX, 7 RWB.
  - 8 BR, 9 J, 10 IEX, 11 IWB, 12 JAL, 13 JR, 14 TRAP, 15 RST.
- RST: all outputs 0. Next state IF.
- IF: MemRead=1, IorD=0, ALUSrc_A=0, ALUSrc_B=01, ALU_Control=010, PCSource=00.
  - IRWrite and PCWrite are asserted only in the cycle mem_ready=1; then go to ID.
  - Otherwise stay in IF.
- ID: ALUSrc_A=0, ALUSrc_B=11, ALU_Control=010 (branch target precompute). Dispatch on opcode:
  - 000000 with funct 001000: JR. Other 000000: REX.
  - 100011 / 101011: MADDR.
  - 000100 / 000101: BR.
  - 000010: J. 000011: JAL.
  - 001000 / 001010 / 001111: IEX.
  - Anything else: TRAP.
- MADDR: ALUSrc_A=1, ALUSrc_B=10, ALU_Control=010. Next MRD for lw, MWR for sw.
- MRD: MemRead=1, IorD=1. Hold until mem_ready, then LWB.
- MWR: MemWrite=1, IorD=1. Hold until mem_ready, then IF.
- LWB: RegWrite=1, RegDst=0, DatatoReg=01. Next IF.
- REX: ALUSrc_A=1, ALUSrc_B=00. ALU_Control from funct:
  - 100000 add → 010, 100010 sub → 110, 100100 and → 000, 100101 or → 001.
  - 100110 xor → 011, 100111 nor → 100, 101010 slt → 111, 000010 srl → 101.
  - Unlisted funct: TRAP instead of RWB.
- RWB: RegWrite=1, RegDst=1, DatatoReg=00, ALU_Control held from REX. Next IF.
- BR: ALUSrc_A=1, ALUSrc_B=00, ALU_Control=110, PCSource=01, Branch=01 (beq) or 10 (bne).
  - PCWrite = (beq & zero) | (bne & ~zero). Next IF.
- J: PCWrite=1, PCSource=10. Next IF.
- JAL: PCWrite=1, PCSource=10, RegWrite=1, Jal=1, DatatoReg=10. Next IF.
- JR: ALUSrc_A=1, ALU_Control=001, ALUSrc_B=00, PCSource=00, PCWrite=1. Next IF. (The datapath reads rt=r0, so the ALU passes rs.)
- IEX: ALUSrc_A=1, ALUSrc_B=10. ALU_Control=010 for addi, 111 for slti, 010 for lui (result unused). Next IWB.
- IWB: RegWrite=1, RegDst=0, DatatoReg=11 for lui, else 00. Next IF.
- TRAP: trap=1, PCWrite=1, PCSource=11. Next IF.

## Timing
- Latency in cycles, with zero memory wait: R 4, lw 5, sw 4, beq/bne 3, j 3, jal 3, jr 3, I-type 4, illegal 3.
- Each mem_ready=0 cycle in IF, MRD or MWR adds one cycle. Wait is unbounded, with no timeout.
- rst is sampled on the clock edge. rst=1 in any state, including mid-wait or mid-instruction, forces RST at the next edge. All outputs are 0 while rst is high and for the first cycle after it deasserts. Fetch starts on the second edge after rst falls.
- mem_ready is ignored in states that issue no memory strobe.
- In IF, PCWrite and IRWrite assert together, only in the mem_ready cycle.

## Configuration
- OVERFLOW_TRAP_EN defined: in RWB for add/sub, and in IWB for addi, overflow=1 forces RegWrite=0 and the next state is TRAP instead of IF.
- OVERFLOW_TRAP_EN undefined: overflow is ignored, and TRAP is reached only by an illegal opcode or funct.

## Test plan
- rst held 3 cycles, then released, mem_ready=1: state 15 for one cycle with all outputs 0, then 0,1,...; IF shows PCWrite=1, IRWrite=1, ALU_Control=010.
- opcode=000000, funct=100111, mem_ready=1: states 0,1,6,7,0; RWB shows RegWrite=1, RegDst=1, ALU_Control=100.
- lw (100011) with mem_ready low 2 cycles in MRD: states 0,1,2,3,3,3,4,0; MemRead=1, IorD=1 throughout the MRD wait.
- bne (000101) with zero=0, then with zero=1: PCWrite=1 with PCSource=01 in the first case, PCWrite=0 in the second; Branch=10 in BR both times.
- opcode=111111: states 0,1,14,0; trap=1 and PCSource=11 in TRAP.
- With OVERFLOW_TRAP_EN, add with overflow=1: RWB has RegWrite=0, next state 14. Without the macro: RegWrite=1, next state 0.
